// File: rtl/mavg_sched_pkg.sv
// Shared types and width helpers for the time-multiplexed moving-average
// scheduler. Optional warm-up gating is selected with MAVG_WARMUP_GATE_EN
// in the top module; nothing here depends on it.
package mavg_sched_pkg;

  // Scheduler FSM: memory clear, arbitration, RAM read, update, output hold.
  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    RD    = 3'd2,
    UPD   = 3'd3,
    OUT   = 3'd4
  } state_t;

  // Channel index width; a single-channel build still needs one bit.
  function automatic int calc_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Running-sum width: WIN samples of DATA_W bits can never exceed this.
  function automatic int calc_sum_w(input int data_w, input int log2_win);
    return data_w + log2_win;
  endfunction

endpackage

// File: rtl/mavg_window_ram.sv
// Window sample store shared by all channels: one write port, one read
// port, both synchronous. Contents are not reset; the scheduler clears
// the array explicitly after reset and on flush.
module mavg_window_ram
  import mavg_sched_pkg::*;
#(
  parameter int DEPTH  = 48,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Registered write and registered read; read data appears one cycle
  // after re is sampled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mavg_channel_scheduler.sv
// Time-multiplexed running-sum moving average for NUM_CH channels.
// A round-robin arbiter picks one channel's sample; the FSM reads the
// oldest window entry, updates that channel's running sum, overwrites
// the entry and presents sum/WIN tagged with the channel number.
//
// Optional build macro: MAVG_WARMUP_GATE_EN -- when defined, a channel
// emits nothing until its window holds WIN real samples.
//
// Handshakes: a beat moves on a rising edge where valid and ready are
// both high. Input side: in_ready is a one-hot grant, combinational from
// state, rr and in_valid; in_valid may drop without a transfer. Output
// side: once out_valid rises, out_data/out_ch stay frozen until the edge
// where out_ready is high.
module mavg_channel_scheduler
  import mavg_sched_pkg::*;
#(
  parameter  int NUM_CH   = 3,
  parameter  int DATA_W   = 8,
  parameter  int LOG2_WIN = 4,
  localparam int CH_W     = calc_ch_w(NUM_CH),
  localparam int SUM_W    = calc_sum_w(DATA_W, LOG2_WIN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     busy
);

  localparam int WIN    = 1 << LOG2_WIN;
  localparam int DEPTH  = NUM_CH * WIN;
  localparam int ADDR_W = CH_W + LOG2_WIN;
`ifdef MAVG_WARMUP_GATE_EN
  localparam int CNT_W  = LOG2_WIN + 1;
`endif

  // FSM state is kept as a plain named register so checkers can bind to it.
  state_t              state;
  logic [CH_W-1:0]     rr;
  logic [CH_W-1:0]     ch;
  logic [DATA_W-1:0]   sample;
  logic [ADDR_W-1:0]   clr_addr;
  logic [SUM_W-1:0]    sum  [NUM_CH];
  logic [LOG2_WIN-1:0] wptr [NUM_CH];
`ifdef MAVG_WARMUP_GATE_EN
  logic [CNT_W-1:0]    count [NUM_CH];
  logic [CNT_W-1:0]    cnt_next;
`endif

  // Arbiter results
  logic [NUM_CH-1:0]   gnt;
  logic [CH_W-1:0]     gnt_ch;
  logic                gnt_any;
  logic [DATA_W-1:0]   sel_data;

  // Datapath
  logic [ADDR_W-1:0]   cur_addr;
  logic [SUM_W-1:0]    sum_next;
  logic [CH_W-1:0]     rr_next;

  // RAM port signals
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;
  logic                ram_re;
  logic [DATA_W-1:0]   ram_rdata;

  assign busy = (state == CLEAR);

  // Round-robin search: first requesting channel at or after rr, wrapping.
  // Grant only in IDLE and never while flush is pending, so flush wins.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_ch  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr) + i;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
      if (!gnt_any && in_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_ch  = CH_W'(idx);
      end
    end
    if (state == IDLE && !flush && gnt_any) begin
      gnt[gnt_ch] = 1'b1;
    end
  end

  assign in_ready = gnt;
  assign sel_data = in_data[gnt_ch*DATA_W +: DATA_W];

  // Window slot for the active channel: the oldest entry, about to be replaced.
  assign cur_addr = {ch, wptr[ch]};

  // Add the new sample, drop the one leaving the window; the sum is bounded
  // by WIN*(2**DATA_W-1), so SUM_W bits never wrap.
  assign sum_next = sum[ch] + SUM_W'(sample) - SUM_W'(ram_rdata);

  // Channel after the one just served becomes the new round-robin start.
  assign rr_next = (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;

`ifdef MAVG_WARMUP_GATE_EN
  // Saturating fill level of the active channel after this update.
  assign cnt_next = (count[ch] == CNT_W'(WIN)) ? count[ch] : count[ch] + 1'b1;
`endif

  // RAM port steering: zero-fill in CLEAR, read oldest in RD, write new in UPD.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cur_addr;
    ram_wdata = sample;
    ram_re    = 1'b0;
    case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr;
        ram_wdata = '0;
      end
      RD: begin
        ram_re = 1'b1;
      end
      UPD: begin
        ram_we = 1'b1;
      end
      default: begin
      end
    endcase
  end

  mavg_window_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (cur_addr),
    .rdata (ram_rdata)
  );

  // Scheduler FSM with all registered outputs and per-channel state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      rr        <= '0;
      ch        <= '0;
      sample    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum[c]  <= '0;
        wptr[c] <= '0;
`ifdef MAVG_WARMUP_GATE_EN
        count[c] <= '0;
`endif
      end
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            // Last slot written: windows are empty, restart every channel.
            clr_addr <= '0;
            state    <= IDLE;
            for (int c = 0; c < NUM_CH; c++) begin
              sum[c]  <= '0;
              wptr[c] <= '0;
`ifdef MAVG_WARMUP_GATE_EN
              count[c] <= '0;
`endif
            end
          end
        end

        IDLE: begin
          if (flush) begin
            state <= CLEAR;
          end else if (gnt_any) begin
            ch     <= gnt_ch;
            sample <= sel_data;
            state  <= RD;
          end
        end

        RD: begin
          state <= UPD;
        end

        UPD: begin
          sum[ch]  <= sum_next;
          wptr[ch] <= wptr[ch] + 1'b1;
`ifdef MAVG_WARMUP_GATE_EN
          count[ch] <= cnt_next;
          if (cnt_next != CNT_W'(WIN)) begin
            // Window not yet full: swallow the result, keep arbitration fair.
            rr    <= rr_next;
            state <= IDLE;
          end else begin
            out_data  <= sum_next[SUM_W-1:LOG2_WIN];
            out_ch    <= ch;
            out_valid <= 1'b1;
            state     <= OUT;
          end
`else
          out_data  <= sum_next[SUM_W-1:LOG2_WIN];
          out_ch    <= ch;
          out_valid <= 1'b1;
          state     <= OUT;
`endif
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rr        <= rr_next;
            state     <= IDLE;
          end
        end

        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mavg_channel_scheduler.sv
// Directed bench for mavg_channel_scheduler (default build, 3 channels,
// 8-bit samples, 16-sample window). Outputs accepted by the sink are
// checked against an expected queue filled with hand-computed averages.
module tb_mavg_channel_scheduler;

  localparam int NUM_CH   = 3;
  localparam int DATA_W   = 8;
  localparam int LOG2_WIN = 4;
  localparam int CH_W     = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_ready;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     busy;

  int n_vec = 0;
  int n_err = 0;

  logic [CH_W+DATA_W-1:0] exp_q[$];
  logic [CH_W+DATA_W-1:0] mon_e;

  mavg_channel_scheduler #(
    .NUM_CH   (NUM_CH),
    .DATA_W   (DATA_W),
    .LOG2_WIN (LOG2_WIN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .busy      (busy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (errors so far %0d)", n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  // Scoreboard: every accepted output must match the head of exp_q.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("out_unexpected", {22'd0, out_ch, out_data}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("out_ch_data", {22'd0, out_ch, out_data}, {22'd0, mon_e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offer sample d on channel c (called at posedge+1), complete the
  // handshake, then return at the first negedge with out_valid high.
  // lat = edges from the start of the handshake cycle to out_valid.
  task automatic push(input int c, input logic [7:0] d, output int lat);
    int n;
    in_data[c*DATA_W +: DATA_W] = d;
    in_valid[c] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready[c] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("grant_wait", {31'd0, in_ready[c]}, 32'd1);
    @(posedge clk); #1;
    in_valid[c] = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Count busy cycles after reset/flush release (called at posedge+1);
  // returns at the first negedge with busy low.
  task automatic wait_clear(output int n, output int noisy);
    n = 0;
    noisy = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      if (in_ready != '0 || out_valid) noisy++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_clear(input string tag);
    int n;
    int noisy;
    wait_clear(n, noisy);
    check_eq({tag, "_len"}, n, 48);
    check_eq({tag, "_quiet"}, noisy, 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_clear(tag);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int e;
    int n;

    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset values; a ch0 sample of 16 is already waiting.
    in_valid[0]  = 1'b1;
    in_data[7:0] = 8'd16;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", {31'd0, out_valid}, 0);
    check_eq("rst_out_data", {24'd0, out_data}, 0);
    check_eq("rst_out_ch", {30'd0, out_ch}, 0);
    check_eq("rst_in_ready", {29'd0, in_ready}, 0);
    check_eq("rst_busy", {31'd0, busy}, 1);

    // Release: 48 busy cycles, then the waiting sample is granted.
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_clear("clear0");
    check_eq("gnt_after_clear", {29'd0, in_ready}, 32'd1);
    exp_q.push_back({2'd0, 8'd1});
    @(posedge clk); #1;
    in_valid = '0;
    wait_drain("drain_first");

    // Flush in IDLE beats a pending sample and replays the clear.
    @(posedge clk); #1;
    flush = 1'b1;
    in_valid[1] = 1'b1;
    in_data[15:8] = 8'd50;
    @(negedge clk);
    check_eq("flush_prio", {29'd0, in_ready}, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = '0;
    check_clear("flush");

    // ch0 fed 160 seventeen times: 10,20,...,160 then steady 160.
    @(posedge clk); #1;
    for (int k = 1; k <= 17; k++) begin
      e = (k <= 16) ? 10 * k : 160;
      exp_q.push_back({2'd0, 8'(e)});
      push(0, 8'd160, lat);
      check_eq("lat_ch0", lat, 3);
      @(posedge clk); #1;
    end
    wait_drain("drain_ch0");

    // Round robin with all channels requesting: 0,1,2,0,1,2.
    do_reset("rst_rr");
    @(posedge clk); #1;
    in_data  = {8'd144, 8'd96, 8'd48};
    in_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      int c;
      int r;
      c = k % 3;
      r = k / 3;
      exp_q.push_back({2'(c), 8'(3 * (c + 1) * (r + 1))});
      n = 0;
      @(negedge clk);
      while (in_ready == '0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check_eq("rr_grant", {29'd0, in_ready}, 32'd1 << c);
      @(posedge clk); #1;
    end
    in_valid = '0;
    wait_drain("drain_rr");

    // Output stall: ch2 holds 144,144; add 16 -> 304/16 = 19.
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(2, 8'd16, lat);
    check_eq("lat_stall", lat, 3);
    for (int i = 0; i < 10; i++) begin
      check_eq("stall_valid", {31'd0, out_valid}, 1);
      check_eq("stall_data", {24'd0, out_data}, 19);
      check_eq("stall_ch", {30'd0, out_ch}, 2);
      check_eq("stall_in_ready", {29'd0, in_ready}, 0);
      @(posedge clk); #1;
      if (i == 0) begin
        in_valid[0]  = 1'b1;
        in_data[7:0] = 8'd5;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    out_ready   = 1'b1;
    exp_q.push_back({2'd2, 8'd19});
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("release_valid", {31'd0, out_valid}, 0);
    check_eq("release_once", exp_q.size(), 0);

    // ch1: sixteen 255s (peak 255), then sixteen 0s (ends at 0).
    do_reset("rst_sat");
    @(posedge clk); #1;
    for (int k = 1; k <= 16; k++) begin
      exp_q.push_back({2'd1, 8'((255 * k) >> 4)});
      push(1, 8'd255, lat);
      check_eq("lat_ch1", lat, 3);
      @(posedge clk); #1;
    end
    wait_drain("drain_peak");
    check_eq("peak_data", {24'd0, out_data}, 255);
    @(posedge clk); #1;
    for (int k = 1; k <= 16; k++) begin
      exp_q.push_back({2'd1, 8'((255 * (16 - k)) >> 4)});
      push(1, 8'd0, lat);
      @(posedge clk); #1;
    end
    wait_drain("drain_fall");
    check_eq("final_zero", {24'd0, out_data}, 0);
    check_eq("final_ch", {30'd0, out_ch}, 1);

    // Reset while holding an output: it is dropped and clear replays.
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(0, 8'd200, lat);
    check_eq("pre_rst_valid", {31'd0, out_valid}, 1);
    do_reset("rst_out");
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back({2'd0, 8'd1});
    push(0, 8'd16, lat);
    check_eq("lat_post_rst", lat, 3);
    @(posedge clk); #1;
    wait_drain("drain_post_rst");

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
